div_issue_ctrl: RTL and testbench

//  Shares the single iterative divider (DIV/DIVU/REM/REMU) between N_REQ issue

---
 rtl/div_issue_ctrl_pkg.sv | 25 ++
 rtl/div_rr_arbiter.sv | 39 +++
 rtl/div_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller.
//   - default sizing for the request ports (N_REQ, TAG_W, ID_W)
//   - controller state encoding (IDLE/ISSUE/WAIT/RESP/DRAIN)
package div_issue_ctrl_pkg;

  localparam int unsigned DIV_N_REQ_DEF = 2;
  localparam int unsigned DIV_TAG_W_DEF = 5;
  localparam int unsigned DIV_ID_W_DEF  = 1;

  // Encodings kept identical to the legacy block so waveform decoders still match.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP,
    S_DRAIN = ST_DRAIN
  } div_state_t;

endpackage

// File: rtl/div_rr_arbiter.sv
// Round-robin arbiter for the divider issue ports.
//   req_i   : request vector, one bit per port
//   ptr_i   : highest-priority port this cycle
//   grant_o : one-hot grant (0 when nothing requests)
//   idx_o   : index of the granted port
//   valid_o : some port was granted
module div_rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             valid_o
);

  int unsigned     cand;
  logic [ID_W-1:0] cand_idx;

  // Scan ports starting at ptr_i, wrapping; first requester wins.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand     = (32'(ptr_i) + i) % N_REQ;
      cand_idx = ID_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o           = 1'b1;
        idx_o             = cand_idx;
        grant_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Shares one iterative divider between N_REQ issue ports.
// Accepts one request at a time (round-robin), launches it, waits for the
// divider's variable-latency writeback and returns the result tagged with
// requester id and instruction tag.
//   clk_i, rstn_i          clock, async active-low reset
//   req_*                  per-port request (valid/ready, opcode, ra, rb, tag)
//   div_valid_o/opcode/ra/rb  launch interface to the divider
//   div_wb_valid_i/value_i    divider writeback
//   rsp_*                  tagged result (valid/ready, id, tag, value)
//   flush_i                discard in-flight operation
//   busy_o                 controller not idle
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = DIV_N_REQ_DEF,
  parameter int unsigned TAG_W = DIV_TAG_W_DEF,
  parameter int unsigned ID_W  = DIV_ID_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*32-1:0]    req_opcode_i,
  input  logic [N_REQ*32-1:0]    req_ra_i,
  input  logic [N_REQ*32-1:0]    req_rb_i,
  input  logic [N_REQ*TAG_W-1:0] req_tag_i,
  output logic                   div_valid_o,
  output logic [31:0]            div_opcode_o,
  output logic [31:0]            div_ra_o,
  output logic [31:0]            div_rb_o,
  input  logic                   div_wb_valid_i,
  input  logic [31:0]            div_wb_value_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [TAG_W-1:0]       rsp_tag_o,
  output logic [31:0]            rsp_value_o,
  input  logic                   flush_i,
  output logic                   busy_o
);

  div_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [N_REQ-1:0] arb_grant;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_valid;
  logic             accept;
  logic [31:0]      sel_opcode, sel_ra, sel_rb;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      opcode_q, ra_q, rb_q, value_q;
  logic [ID_W-1:0]  id_q;
  logic [TAG_W-1:0] tag_q;

  div_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // rstn_i gating keeps req_ready_o low while reset is held.
  assign accept      = rstn_i && (state_q == S_IDLE) && arb_valid && !flush_i;
  assign req_ready_o = accept ? arb_grant : '0;

  always_comb begin
    sel_opcode = '0;
    sel_ra     = '0;
    sel_rb     = '0;
    sel_tag    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_opcode = req_opcode_i[i*32 +: 32];
        sel_ra     = req_ra_i[i*32 +: 32];
        sel_rb     = req_rb_i[i*32 +: 32];
        sel_tag    = req_tag_i[i*TAG_W +: TAG_W];
      end
    end
  end

  // A flushed op is still tracked until its writeback (DRAIN) so a new launch
  // can never restart the divider mid-operation.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = flush_i ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (div_wb_valid_i)  state_d = flush_i ? S_IDLE : S_RESP;
        else if (flush_i)    state_d = S_DRAIN;
      end
      S_RESP:  if (flush_i || rsp_ready_i) state_d = S_IDLE;
      S_DRAIN: if (div_wb_valid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      id_q     <= '0;
      tag_q    <= '0;
      value_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_ptr_q <= (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
        opcode_q <= sel_opcode;
        ra_q     <= sel_ra;
        rb_q     <= sel_rb;
        id_q     <= arb_idx;
        tag_q    <= sel_tag;
      end
      if (state_q == S_WAIT && div_wb_valid_i && !flush_i) begin
        value_q <= div_wb_value_i;
      end
    end
  end

  assign div_valid_o  = (state_q == S_ISSUE);
  assign div_opcode_o = opcode_q;
  assign div_ra_o     = ra_q;
  assign div_rb_o     = rb_q;
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_id_o     = id_q;
  assign rsp_tag_o    = tag_q;
  assign rsp_value_o  = value_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_opcode_i, req_ra_i, req_rb_i;
  logic [9:0]  req_tag_i;
  logic        div_valid_o;
  logic [31:0] div_opcode_o, div_ra_o, div_rb_o;
  logic        div_wb_valid_i = 1'b0;
  logic [31:0] div_wb_value_i = '0;
  logic        rsp_valid_o, rsp_ready_i;
  logic [0:0]  rsp_id_o;
  logic [4:0]  rsp_tag_o;
  logic [31:0] rsp_value_o;
  logic        flush_i, busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.N_REQ(2), .TAG_W(5), .ID_W(1)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opcode_i(req_opcode_i), .req_ra_i(req_ra_i), .req_rb_i(req_rb_i),
    .req_tag_i(req_tag_i),
    .div_valid_o(div_valid_o), .div_opcode_o(div_opcode_o),
    .div_ra_o(div_ra_o), .div_rb_o(div_rb_o),
    .div_wb_valid_i(div_wb_valid_i), .div_wb_value_i(div_wb_value_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_tag_o(rsp_tag_o), .rsp_value_o(rsp_value_o),
    .flush_i(flush_i), .busy_o(busy_o)
  );

  // RV32M opcode with given funct3 (4 DIV, 5 DIVU, 6 REM, 7 REMU)
  function automatic logic [31:0] mop(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] div_ref(input logic [31:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op[14:12])
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Divider behavioural model: 34-cycle latency, 2 cycles on an exact repeat.
  int unsigned launches = 0;
  int unsigned overlaps = 0;
  logic        m_busy   = 1'b0;
  int          m_cnt    = 0;
  logic [31:0] m_res    = '0;
  logic [31:0] p_op = '0, p_ra = '0, p_rb = '0;
  logic        p_valid  = 1'b0;

  always @(negedge clk) begin
    div_wb_valid_i = 1'b0;
    if (!rstn_i) begin
      m_busy  = 1'b0;
      p_valid = 1'b0;
    end else if (div_valid_o) begin
      if (m_busy) overlaps++;
      launches++;
      m_cnt   = (p_valid && p_op == div_opcode_o && p_ra == div_ra_o && p_rb == div_rb_o) ? 2 : 34;
      p_op    = div_opcode_o;
      p_ra    = div_ra_o;
      p_rb    = div_rb_o;
      p_valid = 1'b1;
      m_res   = div_ref(div_opcode_o, div_ra_o, div_rb_o);
      m_busy  = 1'b1;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        div_wb_valid_i = 1'b1;
        div_wb_value_i = m_res;
        m_busy         = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int p, input logic [31:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] t);
    req_opcode_i[p*32 +: 32] = op;
    req_ra_i[p*32 +: 32]     = a;
    req_rb_i[p*32 +: 32]     = b;
    req_tag_i[p*5 +: 5]      = t;
    req_valid_i[p]           = 1'b1;
  endtask

  // Returns at the negedge of the ISSUE cycle.
  task automatic wait_accept(input string nm, input logic [1:0] g);
    int n = 0;
    #1;
    while (req_ready_o == '0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, "_grant"}, 32'(req_ready_o), 32'(g));
    @(negedge clk); #1;
    chk({nm, "_launch"}, 32'(div_valid_o), 32'd1);
  endtask

  task automatic wait_rsp(input string nm, input logic id, input logic [4:0] tag,
                          input logic [31:0] val, output int n);
    n = 0;
    while (!rsp_valid_o && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, "_valid"}, 32'(rsp_valid_o), 32'd1);
    chk({nm, "_id"}, 32'(rsp_id_o), 32'(id));
    chk({nm, "_tag"}, 32'(rsp_tag_o), 32'(tag));
    chk({nm, "_value"}, rsp_value_o, val);
  endtask

  task automatic ack_rsp(input string nm);
    rsp_ready_i = 1'b1;
    @(negedge clk); #1;
    rsp_ready_i = 1'b0;
    chk({nm, "_done"}, 32'(rsp_valid_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int unsigned l0;
    rstn_i = 1'b0; flush_i = 1'b0; rsp_ready_i = 1'b0;
    req_valid_i = 2'b11; req_opcode_i = '0; req_ra_i = '0; req_rb_i = '0; req_tag_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("rst_div_valid", 32'(div_valid_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_div_ra", div_ra_o, 0);
    req_valid_i = 2'b00;
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);

    // DIV -7/2 from port 0, then stall the consumer for 20 cycles
    drive_req(0, mop(3'd4), 32'hFFFF_FFF9, 32'd2, 5'd3);
    wait_accept("t1", 2'b01);
    chk("t1_div_ra", div_ra_o, 32'hFFFF_FFF9);
    chk("t1_div_rb", div_rb_o, 32'd2);
    req_valid_i[0] = 1'b0;
    wait_rsp("t1", 1'b0, 5'd3, 32'hFFFF_FFFD, n);
    l0 = launches;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("stall_valid", 32'(rsp_valid_o), 1);
      chk("stall_value", rsp_value_o, 32'hFFFF_FFFD);
      chk("stall_tag", 32'(rsp_tag_o), 3);
    end
    chk("stall_launches", launches, l0);
    ack_rsp("t1");

    // DIVU 5/0 from port 1
    drive_req(1, mop(3'd5), 32'd5, 32'd0, 5'd7);
    wait_accept("t2", 2'b10);
    req_valid_i[1] = 1'b0;
    wait_rsp("t2", 1'b1, 5'd7, 32'hFFFF_FFFF, n);
    ack_rsp("t2");

    // simultaneous pair, pointer at 0; port 0 re-requests immediately
    drive_req(0, mop(3'd7), 32'd100, 32'd7, 5'd1);
    drive_req(1, mop(3'd5), 32'd100, 32'd7, 5'd2);
    wait_accept("t3a", 2'b01);
    drive_req(0, mop(3'd6), 32'd5, 32'd0, 5'd4);
    wait_rsp("t3a", 1'b0, 5'd1, 32'd2, n);
    ack_rsp("t3a");
    wait_accept("t3b", 2'b10);
    req_valid_i[1] = 1'b0;
    wait_rsp("t3b", 1'b1, 5'd2, 32'd14, n);
    ack_rsp("t3b");
    wait_accept("t3c", 2'b01);
    req_valid_i[0] = 1'b0;
    wait_rsp("t3c", 1'b0, 5'd4, 32'd5, n);
    ack_rsp("t3c");

    // identical DIVU 100/7 back-to-back: second uses the divider's fast path
    l0 = launches;
    drive_req(0, mop(3'd5), 32'd100, 32'd7, 5'd5);
    wait_accept("t4a", 2'b01);
    req_valid_i[0] = 1'b0;
    wait_rsp("t4a", 1'b0, 5'd5, 32'd14, n);
    chk("t4a_latency", 32'(n), 32'd35);
    ack_rsp("t4a");
    drive_req(0, mop(3'd5), 32'd100, 32'd7, 5'd5);
    wait_accept("t4b", 2'b01);
    req_valid_i[0] = 1'b0;
    @(negedge clk); #1;
    chk("t4b_single_pulse", 32'(div_valid_o), 0);
    wait_rsp("t4b", 1'b0, 5'd5, 32'd14, n);
    chk("t4b_latency", 32'(n), 32'd2);
    chk("t4_launches", launches - l0, 32'd2);
    ack_rsp("t4b");

    // flush 10 cycles into WAIT; port 0 waits behind the drain
    drive_req(1, mop(3'd4), 32'hFFFF_FFF9, 32'd2, 5'd6);
    wait_accept("t5", 2'b10);
    req_valid_i[1] = 1'b0;
    repeat (10) @(negedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk); #1;
    flush_i = 1'b0;
    drive_req(0, mop(3'd5), 32'd100, 32'd7, 5'd8);
    #1;
    n = 0;
    while (busy_o && n < 100) begin
      chk("drain_ready", 32'(req_ready_o), 0);
      chk("drain_rsp", 32'(rsp_valid_o), 0);
      @(negedge clk); #1;
      n++;
    end
    chk("drain_cycles", 32'(n), 32'd24);
    wait_accept("t5b", 2'b01);
    req_valid_i[0] = 1'b0;
    wait_rsp("t5b", 1'b0, 5'd8, 32'd14, n);
    ack_rsp("t5b");

    // flush while in RESP
    drive_req(1, mop(3'd7), 32'd100, 32'd7, 5'd9);
    wait_accept("t6", 2'b10);
    req_valid_i[1] = 1'b0;
    wait_rsp("t6", 1'b1, 5'd9, 32'd2, n);
    flush_i = 1'b1;
    @(negedge clk); #1;
    flush_i = 1'b0;
    chk("t6_rsp_dropped", 32'(rsp_valid_o), 0);
    chk("t6_idle", 32'(busy_o), 0);

    // flush coincides with writeback in WAIT
    drive_req(0, mop(3'd5), 32'd5, 32'd0, 5'd10);
    wait_accept("t7", 2'b01);
    req_valid_i[0] = 1'b0;
    repeat (34) @(negedge clk);
    #1 flush_i = 1'b1;
    chk("t7_wb_aligned", 32'(div_wb_valid_i), 1);
    @(negedge clk); #1;
    flush_i = 1'b0;
    chk("t7_no_rsp", 32'(rsp_valid_o), 0);
    chk("t7_idle", 32'(busy_o), 0);

    // reset mid-operation; pointer (1 beforehand) returns to 0
    drive_req(0, mop(3'd4), 32'hFFFF_FFF9, 32'd2, 5'd11);
    wait_accept("t8", 2'b01);
    repeat (5) @(negedge clk);
    #1 rstn_i = 1'b0;
    #1;
    chk("t8_busy", 32'(busy_o), 0);
    chk("t8_div_valid", 32'(div_valid_o), 0);
    chk("t8_rsp", 32'(rsp_valid_o), 0);
    drive_req(0, mop(3'd5), 32'd100, 32'd7, 5'd12);
    drive_req(1, mop(3'd7), 32'd100, 32'd7, 5'd13);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    wait_accept("t8a", 2'b01);
    req_valid_i[0] = 1'b0;
    wait_rsp("t8a", 1'b0, 5'd12, 32'd14, n);
    ack_rsp("t8a");
    wait_accept("t8b", 2'b10);
    req_valid_i[1] = 1'b0;
    wait_rsp("t8b", 1'b1, 5'd13, 32'd2, n);
    ack_rsp("t8b");

    chk("no_overlap_launch", overlaps, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
